// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StWaitRsp,
    StHold
  } fetch_state_e;

  typedef enum logic [1:0] {
    EpcPc,
    EpcInstPc,
    EpcRedirect
  } epc_src_e;

  localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
  localparam logic [31:0] DefaultExcVector   = 32'h8000_0180;
  localparam logic [31:0] PcInc              = 32'd4;

endpackage

// File: rtl/next_pc_sel.sv
// Resolves exception/redirect priority into a single fetch target and epc source.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DefaultExcVector
) (
  input  logic        en_i,
  input  logic        in_hold_i,
  input  logic        exc_valid_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] target_o,
  output logic        take_event_o,
  output logic        epc_we_o,
  output logic [1:0]  epc_src_o,
  output logic        addr_err_o
);

  logic misaligned;
  assign misaligned = (redirect_pc_i[1:0] != 2'b00);

  always_comb begin
    target_o     = redirect_pc_i;
    take_event_o = 1'b0;
    epc_we_o     = 1'b0;
    epc_src_o    = EpcPc;
    addr_err_o   = 1'b0;
    if (en_i) begin
      if (exc_valid_i) begin
        take_event_o = 1'b1;
        target_o     = EXC_VECTOR;
        epc_we_o     = 1'b1;
        epc_src_o    = in_hold_i ? EpcInstPc : EpcPc;
      end else if (redirect_valid_i) begin
        take_event_o = 1'b1;
        // A misaligned target is promoted to an exception that reports the bad target.
        if (misaligned) begin
          target_o   = EXC_VECTOR;
          epc_we_o   = 1'b1;
          epc_src_o  = EpcRedirect;
          addr_err_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC: one outstanding imem request, holds the fetched word for decode,
// applies exception/redirect events and drops responses made stale by them.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DefaultResetVector,
  parameter logic [31:0] EXC_VECTOR   = DefaultExcVector
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  output logic [31:0] epc,
  output logic        addr_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_data_q, inst_data_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  epc_q, epc_d;
  logic         addr_err_q, addr_err_d;
  logic         stale_q, stale_d;

  logic [31:0]  ev_target;
  logic         ev_take, ev_epc_we, ev_addr_err;
  logic [1:0]   ev_epc_src;
  logic         req_fire, rsp_fire;

  next_pc_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc_sel (
    .en_i             (state_q != StBoot),
    .in_hold_i        (state_q == StHold),
    .exc_valid_i      (exc_valid),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .target_o         (ev_target),
    .take_event_o     (ev_take),
    .epc_we_o         (ev_epc_we),
    .epc_src_o        (ev_epc_src),
    .addr_err_o       (ev_addr_err)
  );

  assign req_fire = (state_q == StReq) && imem_req_ready;
  assign rsp_fire = (state_q == StWaitRsp) && imem_rsp_valid;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    epc_d        = epc_q;
    addr_err_d   = 1'b0;
    stale_d      = stale_q;

    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        if (ev_take) pc_d = ev_target;
        if (req_fire) begin
          state_d = StWaitRsp;
          // The old address is already in flight; its response must be dropped.
          if (ev_take) stale_d = 1'b1;
        end
      end
      StWaitRsp: begin
        if (ev_take) begin
          pc_d = ev_target;
          if (rsp_fire) begin
            stale_d = 1'b0;
            state_d = StReq;
          end else begin
            stale_d = 1'b1;
          end
        end else if (rsp_fire) begin
          if (stale_q) begin
            stale_d = 1'b0;
            state_d = StReq;
          end else begin
            inst_data_d  = imem_rsp_data;
            inst_pc_d    = pc_q;
            pc_d         = pc_q + PcInc;
            inst_valid_d = 1'b1;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (ev_take) begin
          inst_valid_d = 1'b0;
          pc_d         = ev_target;
          state_d      = StReq;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = StReq;
        end
      end
      default: state_d = StBoot;
    endcase

    if (ev_take) addr_err_d = ev_addr_err;
    if (ev_epc_we) begin
      unique case (ev_epc_src)
        EpcInstPc:   epc_d = inst_pc_q;
        EpcRedirect: epc_d = redirect_pc;
        default:     epc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StBoot;
      pc_q         <= RESET_VECTOR;
      inst_data_q  <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      epc_q        <= 32'h0;
      addr_err_q   <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      epc_q        <= epc_d;
      addr_err_q   <= addr_err_d;
      stale_q      <= stale_d;
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign epc            = epc_q;
  assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner sequences, random vs. model.
module tb_fetch_sequencer;

  localparam logic [31:0] ExcVec = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_valid;
  logic [31:0] epc;
  logic        addr_err;

  fetch_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .epc            (epc),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, " inst_valid"}, {31'd0, inst_valid}, 32'd0);
    check({tag, " inst_data"}, inst_data, 32'd0);
    check({tag, " inst_pc"}, inst_pc, 32'd0);
    check({tag, " epc"}, epc, 32'd0);
    check({tag, " addr_err"}, {31'd0, addr_err}, 32'd0);
  endtask

  // Vector table for the straight-line fetch sequence (ready memory and decode).
  typedef struct {
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_ipc;
    logic [31:0] exp_idata;
  } vec_t;
  vec_t vecs[9];

  // Reference model: tracks in-flight requests and the held word, not FSM states.
  typedef struct {
    logic [31:0] addr;
    bit          live;
  } req_t;
  req_t        inflight[$];
  bit          m_booted;
  bit          m_held;
  logic [31:0] m_pc, m_hdata, m_hpc, m_epc;
  bit          m_aerr;

  function automatic bit m_req_valid();
    return m_booted && !m_held && (inflight.size() == 0);
  endfunction

  task automatic model_reset();
    inflight.delete();
    m_booted = 0;
    m_held   = 0;
    m_pc     = 32'h0;
    m_hdata  = 32'h0;
    m_hpc    = 32'h0;
    m_epc    = 32'h0;
    m_aerr   = 0;
  endtask

  task automatic model_step();
    bit          ev, fire, rsp;
    logic [31:0] tgt;
    req_t        r;
    m_aerr = 0;
    if (!m_booted) begin
      m_booted = 1;
      return;
    end
    fire = m_req_valid() && imem_req_ready;
    rsp  = (inflight.size() != 0) && imem_rsp_valid;
    ev   = exc_valid || redirect_valid;
    tgt  = redirect_pc;
    if (exc_valid) begin
      tgt   = ExcVec;
      m_epc = m_held ? m_hpc : m_pc;
    end else if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
      tgt    = ExcVec;
      m_epc  = redirect_pc;
      m_aerr = 1;
    end
    if (ev) begin
      m_held = 0;
      if (rsp) begin
        void'(inflight.pop_front());
      end else if (fire) begin
        r.addr = m_pc;
        r.live = 0;
        inflight.push_back(r);
      end else if (inflight.size() != 0) begin
        inflight[0].live = 0;
      end
      m_pc = tgt;
    end else begin
      if (m_held && inst_ready) m_held = 0;
      if (fire) begin
        r.addr = m_pc;
        r.live = 1;
        inflight.push_back(r);
      end
      if (rsp) begin
        r = inflight.pop_front();
        if (r.live) begin
          m_held  = 1;
          m_hdata = imem_rsp_data;
          m_hpc   = r.addr;
          m_pc    = r.addr + 32'd4;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rpc;

    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exc_valid      = 1'b0;

    vecs[0] = '{1'b0, 32'h0,         1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA000_0000};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 32'hA000_0001, 1'b0, 32'h0, 1'b1, 32'h4, 32'hA000_0001};
    vecs[6] = '{1'b0, 32'h0,         1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[8] = '{1'b1, 32'hA000_0002, 1'b0, 32'h0, 1'b1, 32'h8, 32'hA000_0002};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n        = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;

    foreach (vecs[i]) begin
      imem_rsp_valid = vecs[i].rsp_v;
      imem_rsp_data  = vecs[i].rsp_d;
      tick();
      check($sformatf("vec%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].exp_rv});
      if (vecs[i].exp_rv) check($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_iv});
      if (vecs[i].exp_iv) begin
        check($sformatf("vec%0d inst_pc", i), inst_pc, vecs[i].exp_ipc);
        check($sformatf("vec%0d inst_data", i), inst_data, vecs[i].exp_idata);
      end
    end
    imem_rsp_valid = 1'b0;

    // Decode stall in HOLD: word stays put, no new request.
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall inst_valid", {31'd0, inst_valid}, 32'd1);
      check("stall inst_pc", inst_pc, 32'h8);
      check("stall inst_data", inst_data, 32'hA000_0002);
      check("stall req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    check("release req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("release addr", imem_addr, 32'hC);
    check("release inst_valid", {31'd0, inst_valid}, 32'd0);

    // Redirect while waiting: the late response must be dropped.
    tick();
    check("wait req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("stale req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("stale dropped inst_valid", {31'd0, inst_valid}, 32'd0);
    check("stale next req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("stale next addr", imem_addr, 32'h100);

    // Exception beats a redirect in HOLD; epc takes the held word's pc.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    tick();
    redirect_valid = 1'b0;
    check("req redirect addr", imem_addr, 32'h8);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    check("hold8 inst_pc", inst_pc, 32'h8);
    inst_ready     = 1'b0;
    exc_valid      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    exc_valid      = 1'b0;
    redirect_valid = 1'b0;
    check("exc epc", epc, 32'h8);
    check("exc flush inst_valid", {31'd0, inst_valid}, 32'd0);
    check("exc next addr", imem_addr, ExcVec);
    check("exc addr_err", {31'd0, addr_err}, 32'd0);

    // Misaligned redirect becomes an exception with an addr_err pulse.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("misalign addr_err", {31'd0, addr_err}, 32'd1);
    check("misalign epc", epc, 32'h102);
    check("misalign addr", imem_addr, ExcVec);
    tick();
    check("misalign addr_err pulse", {31'd0, addr_err}, 32'd0);

    // Asynchronous reset in WAIT_RSP; a late response after release is ignored.
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("pre-reset wait", {31'd0, imem_req_valid}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    @(posedge clk);
    #2;
    reset_n        = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    check("late rsp inst_valid", {31'd0, inst_valid}, 32'd0);
    check("restart req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("restart addr", imem_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_F00D;
    tick();
    imem_rsp_valid = 1'b0;
    check("restart inst_pc", inst_pc, 32'h0);
    check("restart inst_data", inst_data, 32'h0BAD_F00D);

    // Random traffic against the model.
    reset_n = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      imem_rsp_valid = ($urandom_range(0, 2) == 0);
      imem_rsp_data  = $urandom;
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      rpc            = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      redirect_pc    = rpc;
      exc_valid      = ($urandom_range(0, 19) == 0);
      model_step();
      tick();
      check("rnd req_valid", {31'd0, imem_req_valid}, {31'd0, m_req_valid()});
      check("rnd addr", imem_addr, m_pc);
      check("rnd inst_valid", {31'd0, inst_valid}, {31'd0, m_held});
      check("rnd inst_pc", inst_pc, m_hpc);
      check("rnd inst_data", inst_data, m_hdata);
      check("rnd epc", epc, m_epc);
      check("rnd addr_err", {31'd0, addr_err}, {31'd0, m_aerr});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
